// File: rtl/writeback_arbiter_if.sv
// rtl/writeback_arbiter_if.sv - result-port and write-back bus bundle for writeback_arbiter
// Flattened per-unit slices: unit i owns res_rd[i*REG_ADDR_W +: REG_ADDR_W] and res_data[i*XLEN +: XLEN].
interface writeback_arbiter_if #(
   parameter int N_UNITS    = 4,
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic [N_UNITS-1:0]            res_valid;
   logic [N_UNITS-1:0]            res_ready;
   logic [N_UNITS*REG_ADDR_W-1:0] res_rd;
   logic [N_UNITS*XLEN-1:0]       res_data;
   logic                          wb_write;
   logic [REG_ADDR_W-1:0]         wb_address;
   logic [XLEN-1:0]               wb_data;
   logic                          busy;

   modport slave (
      input  res_valid, res_rd, res_data,
      output res_ready, wb_write, wb_address, wb_data, busy
   );

   modport master (
      output res_valid, res_rd, res_data,
      input  res_ready, wb_write, wb_address, wb_data, busy
   );
endinterface

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - per-unit result FIFOs, round-robin pick, registered register-file write port
// Every accepted result with rd!=0 is written exactly once; rd==0 results are dropped at push.
module writeback_arbiter #(
   parameter int N_UNITS    = 4,
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int DEPTH      = 2
) (
   input logic                clk,
   input logic                rst_n,
   writeback_arbiter_if.slave bus
);
   localparam int UW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [N_UNITS-1:0]    w_push;
   logic [N_UNITS-1:0]    w_nonempty;
   logic [N_UNITS-1:0]    w_full;
   logic [N_UNITS-1:0]    w_grant;
   logic [REG_ADDR_W-1:0] w_head_rd   [N_UNITS];
   logic [XLEN-1:0]       w_head_data [N_UNITS];
   logic [UW-1:0]         w_winner;
   logic                  w_any;

   logic [UW-1:0]         r_rr;
   logic                  r_wb_write;
   logic [REG_ADDR_W-1:0] r_wb_address;
   logic [XLEN-1:0]       r_wb_data;

   for (genvar g = 0; g < N_UNITS; g++) begin : g_unit
      logic [CW-1:0]         r_count;
      logic [AW-1:0]         r_wr_ptr;
      logic [AW-1:0]         r_rd_ptr;
      logic [REG_ADDR_W-1:0] r_mem_rd   [DEPTH];
      logic [XLEN-1:0]       r_mem_data [DEPTH];
      logic [REG_ADDR_W-1:0] w_rd;
      logic [XLEN-1:0]       w_data;

      assign w_rd          = bus.res_rd[g*REG_ADDR_W +: REG_ADDR_W];
      assign w_data        = bus.res_data[g*XLEN +: XLEN];
      // Ready depends only on the registered count, so a same-cycle pop never frees a slot.
      assign w_full[g]     = (r_count == CW'(DEPTH));
      assign w_nonempty[g] = (r_count != '0);
      assign w_push[g]     = bus.res_valid[g] && !w_full[g] && (w_rd != '0);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push[g])
               r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_grant[g])
               r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_push[g] && !w_grant[g])
               r_count <= r_count + CW'(1);
            else if (!w_push[g] && w_grant[g])
               r_count <= r_count - CW'(1);
         end
      end

      always_ff @(posedge clk) begin
         if (w_push[g]) begin
            r_mem_rd[r_wr_ptr]   <= w_rd;
            r_mem_data[r_wr_ptr] <= w_data;
         end
      end

      assign w_head_rd[g]   = r_mem_rd[r_rd_ptr];
      assign w_head_data[g] = r_mem_data[r_rd_ptr];
   end

   // First non-empty FIFO after the last winner, wrapping; rr = N_UNITS-1 makes unit 0 first.
   always_comb begin : arb
      logic [UW-1:0] v_idx;
      w_any    = 1'b0;
      w_winner = r_rr;
      w_grant  = '0;
      v_idx    = '0;
      for (int k = 1; k <= N_UNITS; k++) begin
         v_idx = UW'((int'(r_rr) + k) % N_UNITS);
         if (!w_any && w_nonempty[v_idx]) begin
            w_any    = 1'b1;
            w_winner = v_idx;
         end
      end
      if (w_any)
         w_grant[w_winner] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr         <= UW'(N_UNITS - 1);
         r_wb_write   <= 1'b0;
         r_wb_address <= '0;
         r_wb_data    <= '0;
      end else begin
         if (w_any)
            r_rr <= w_winner;
         r_wb_write   <= w_any;
         r_wb_address <= w_any ? w_head_rd[w_winner]   : '0;
         r_wb_data    <= w_any ? w_head_data[w_winner] : '0;
      end
   end

   assign bus.res_ready  = ~w_full;
   assign bus.wb_write   = r_wb_write;
   assign bus.wb_address = r_wb_address;
   assign bus.wb_data    = r_wb_data;
   assign bus.busy       = (|w_nonempty) | r_wb_write;
endmodule
